wb_selftest_master: RTL
=======================

# wb_selftest_master

Synthesizable Wishbone classic single-transfer bus master that runs a write-then-read-back self-test over a parametrised address window. Latches a test pattern mode on `start_i`, writes every word in the window, reads every word back, compares against the expected pattern and reports pass/fail, error count and first failing address. It sits on the shared slave bus beside `sys_block` and `sw_reg_wr`, and gives an in-fabric, repeatable bring-up check.

## Interface
- `BUS_DATA_WIDTH`, 32: data width; one of 8, 16, 32 or 64.
- `BUS_ADDR_WIDTH`, 8: address width.
- `TEST_BASE_ADDR`, 'h00: first word address tested.
- `TEST_HIGH_ADDR`, 'h0F: last word address tested, inclusive; must be >= `TEST_BASE_ADDR`.
- `PATTERN_BASE`, 'hEEEEEEEE: pattern seed, truncated to `BUS_DATA_WIDTH`.
- `TIMEOUT_CYCLES`, 16: maximum number of strobe cycles per transfer, >= 1.

Ports (clock and reset first):
- `wb_clk_i` in 1: the only clock.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: start a test run; sampled only in IDLE or DONE.
- `mode_i` in 1: pattern mode, latched with the start. 0 = incrementing, 1 = inverted incrementing.
- `wbm_cyc_o` out 1: Wishbone cycle.
- `wbm_stb_o` out 1: Wishbone strobe.
- `wbm_we_o` out 1: Wishbone write enable.
- `wbm_sel_o` out `BUS_DATA_WIDTH/8`: byte selects; always all ones.
- `wbm_adr_o` out `BUS_ADDR_WIDTH`: Wishbone address.
- `wbm_dat_o` out `BUS_DATA_WIDTH`: write data.
- `wbm_dat_i` in `BUS_DATA_WIDTH`: read data.
- `wbm_ack_i` in 1: slave acknowledge.
- `wbm_err_i` in 1: slave error.
- `busy_o` out 1: a test run is in progress.
- `done_o` out 1: run complete; held until the next start.
- `pass_o` out 1: `done_o` is high and `err_count_o` is 0.
- `err_count_o` out 16: number of failed transfers, saturating at 'hFFFF.
- `first_fail_adr_o` out `BUS_ADDR_WIDTH`: address of the first failed transfer; 0 if there was none.

## Operation
- **Window size:** N = `TEST_HIGH_ADDR` - `TEST_BASE_ADDR` + 1. Index i runs 0..N-1; address = `TEST_BASE_ADDR` + i.
- **Expected data:** E(i) = `PATTERN_BASE` + i, modulo 2^`BUS_DATA_WIDTH`. Bitwise inverted when the latched mode is 1.
- **States:**
  - IDLE: start goes to WR.
  - WR: one write transfer. On termination, go to WR_GAP; after the last index, go to RD_GAP.
  - WR_GAP: one cycle with bus outputs low, then back to WR.
  - RD_GAP: one cycle with bus outputs low, then RD.
  - RD: one read transfer. On termination, go to RD_GAP; after the last index, go to DONE.
  - DONE: start goes to WR.
- **Start:**
  - Clears `err_count_o`, `first_fail_adr_o`, `done_o` and the index.
  - Latches `mode_i`.
  - `start_i` is ignored in WR, WR_GAP, RD_GAP and RD.
- **Transfer termination:** the first edge on which `stb` is high and any of the following holds:
  - `wbm_ack_i` is high: normal completion.
  - `wbm_err_i` is high: failure.
  - the strobe has been high for `TIMEOUT_CYCLES` cycles: timeout, a failure.
- **Simultaneous ack and err:** err wins.
- **Read compare:** done on the ack edge, full width, against E(i).
- **Failure accounting:**
  - A compare mismatch, an err or a timeout adds one to `err_count_o`.
  - On the first failure of a run, `first_fail_adr_o` captures the current address.
- **Reset:** every output is 0, and the state is IDLE. Reset mid-run aborts the transfer immediately: `cyc`/`stb` drop asynchronously, and nothing is retried after reset.
- **Bus outputs:**
  - `wbm_sel_o` is all ones whenever `stb` is high.
  - `wbm_dat_o` is E(i) during writes.
  - `wbm_adr_o`, `wbm_dat_o` and `wbm_we_o` are stable for the whole strobe.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Edge numbering: start is sampled at edge 0, and `cyc`/`stb`/`we` rise after edge 0.
- Transfer deassertion: when a transfer terminates at edge t, `cyc`/`stb` are low after edge t (the gap cycle), and the next transfer's strobe rises after edge t+1.
- Zero-wait slave (ack on the first strobe cycle): transfer j terminates at edge 2j+1.
  - The last read terminates at edge 4N-1.
  - `done_o` and `pass_o` rise and `busy_o` falls after edge 4N-1.
- Each wait state adds one cycle per transfer. A timeout holds the strobe for exactly `TIMEOUT_CYCLES` cycles.
- `busy_o` rises after edge 0 and is high in every non-IDLE/DONE state.
- `err_count_o` and `first_fail_adr_o` update on the terminating edge.
- Restart: `start_i` in DONE leaves `done_o` low after the same edge, and a new run begins with no idle cycle.

## Test plan
- **Baseline pass:** register-model slave with comb ack, defaults, mode 0, pulse start.
  - Writes `EEEEEEEE`..`EEEEEEFD` to 0x00..0x0F; reads match.
  - `done_o`/`pass_o` high after edge 63; `err_count_o` = 0.
- **Stuck bit:** slave with bit 0 of address 0x05 stuck at 0.
  - `err_count_o` = 1, `first_fail_adr_o` = 0x05, `pass_o` = 0.
- **No-ack timeout:** slave never acks 0x0A, `TIMEOUT_CYCLES` = 8.
  - Strobe held exactly 8 cycles on both the write and the read.
  - `err_count_o` = 2, `first_fail_adr_o` = 0x0A.
  - All other addresses pass, and `done_o` still asserts.
- **Err and wait states:** slave asserts `wbm_err_i` together with ack at 0x03, and adds 2 wait states on every transfer.
  - err wins: `err_count_o` = 2, `first_fail_adr_o` = 0x03.
  - Every transfer takes 4 cycles including the gap.
- **Reset mid-run:** assert `wb_rst_i` during the write of 0x07.
  - `cyc`/`stb` drop without waiting for a clock edge; all outputs are 0.
  - A fresh start then completes with a pass.
- **Inverted mode and restart:** mode 1.
  - Write data is `11111111`, `11111110`, ...
  - `start_i` during the run is ignored.
  - `start_i` in DONE clears `done_o` and restarts.

Source files
------------

// File: rtl/wb_selftest_master.sv
// Wishbone classic bus master that writes a pattern over an address window,
// reads it back, and reports pass/fail, error count and first failing address.
//
// state    | meaning
// S_IDLE   | waiting for start after reset
// S_WR     | write transfer for index idx on the bus
// S_WR_GAP | one idle bus cycle between writes
// S_RD_GAP | one idle bus cycle before each read
// S_RD     | read transfer for index idx on the bus, compared on ack
// S_DONE   | results held until the next start
module wb_selftest_master #(
    parameter int                        BUS_DATA_WIDTH = 32,
    parameter int                        BUS_ADDR_WIDTH = 8,
    parameter logic [BUS_ADDR_WIDTH-1:0] TEST_BASE_ADDR = 'h00,
    parameter logic [BUS_ADDR_WIDTH-1:0] TEST_HIGH_ADDR = 'h0F,
    parameter logic [63:0]               PATTERN_BASE   = 64'hEEEEEEEE,
    parameter int                        TIMEOUT_CYCLES = 16
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        start_i,
    input  logic                        mode_i,
    output logic                        wbm_cyc_o,
    output logic                        wbm_stb_o,
    output logic                        wbm_we_o,
    output logic [BUS_DATA_WIDTH/8-1:0] wbm_sel_o,
    output logic [BUS_ADDR_WIDTH-1:0]   wbm_adr_o,
    output logic [BUS_DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic [BUS_DATA_WIDTH-1:0]   wbm_dat_i,
    input  logic                        wbm_ack_i,
    input  logic                        wbm_err_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        pass_o,
    output logic [15:0]                 err_count_o,
    output logic [BUS_ADDR_WIDTH-1:0]   first_fail_adr_o
);

    localparam int SW = BUS_DATA_WIDTH / 8;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BUS_ADDR_WIDTH-1:0] LAST_IDX = TEST_HIGH_ADDR - TEST_BASE_ADDR;
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_GAP,
        S_RD_GAP,
        S_RD,
        S_DONE
    } state_t;

    state_t                    state, state_d;
    logic [BUS_ADDR_WIDTH-1:0] idx, idx_d;
    logic                      mode_q, mode_d;
    logic [15:0]               err_cnt, err_cnt_d;
    logic [BUS_ADDR_WIDTH-1:0] ff_adr, ff_adr_d;
    logic [TW-1:0]             tmr;

    logic                      xfer, xfer_d, tc, term, fail;
    logic [BUS_ADDR_WIDTH-1:0] cur_adr;
    logic [BUS_DATA_WIDTH-1:0] exp_cur;

    logic                      cyc_q, we_q, busy_q, done_q, pass_q;
    logic [SW-1:0]             sel_q;
    logic [BUS_ADDR_WIDTH-1:0] adr_q;
    logic [BUS_DATA_WIDTH-1:0] dat_q;

    function automatic logic [BUS_DATA_WIDTH-1:0] pattern(
        input logic [BUS_ADDR_WIDTH-1:0] i,
        input logic                      inv
    );
        logic [BUS_DATA_WIDTH-1:0] p;
        p = PATTERN_BASE[BUS_DATA_WIDTH-1:0] + BUS_DATA_WIDTH'(i);
        return inv ? ~p : p;
    endfunction

    always_comb begin
        xfer    = (state == S_WR) || (state == S_RD);
        tc      = (tmr == '0);
        cur_adr = TEST_BASE_ADDR + idx;
        exp_cur = pattern(idx, mode_q);
        term    = xfer && (wbm_ack_i || wbm_err_i || tc);
        // err beats ack; a timeout only counts when no ack arrives on that edge
        fail    = xfer && (wbm_err_i || (!wbm_ack_i && tc) ||
                           ((state == S_RD) && wbm_ack_i && (wbm_dat_i != exp_cur)));
    end

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        mode_d    = mode_q;
        err_cnt_d = err_cnt;
        ff_adr_d  = ff_adr;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d   = S_WR;
                    idx_d     = '0;
                    mode_d    = mode_i;
                    err_cnt_d = '0;
                    ff_adr_d  = '0;
                end
            end
            S_WR: begin
                if (term) begin
                    if (idx == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_RD_GAP;
                    end else begin
                        idx_d   = idx + BUS_ADDR_WIDTH'(1);
                        state_d = S_WR_GAP;
                    end
                end
            end
            S_WR_GAP: state_d = S_WR;
            S_RD_GAP: state_d = S_RD;
            S_RD: begin
                if (term) begin
                    if (idx == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx + BUS_ADDR_WIDTH'(1);
                        state_d = S_RD_GAP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (term && fail) begin
            if (err_cnt == '0) ff_adr_d = cur_adr;
            if (err_cnt != 16'hFFFF) err_cnt_d = err_cnt + 16'd1;
        end
        xfer_d = (state_d == S_WR) || (state_d == S_RD);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= S_IDLE;
            idx     <= '0;
            mode_q  <= 1'b0;
            err_cnt <= '0;
            ff_adr  <= '0;
            tmr     <= TMR_LOAD;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            mode_q  <= mode_d;
            err_cnt <= err_cnt_d;
            ff_adr  <= ff_adr_d;
            // down-counter reloads whenever the strobe is low
            if (!xfer)   tmr <= TMR_LOAD;
            else if (!tc) tmr <= tmr - TW'(1);
            cyc_q   <= xfer_d;
            we_q    <= (state_d == S_WR);
            sel_q   <= {SW{xfer_d}};
            if (xfer_d) begin
                adr_q <= TEST_BASE_ADDR + idx_d;
                if (state_d == S_WR) dat_q <= pattern(idx_d, mode_d);
            end
            busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q  <= (state_d == S_DONE);
            pass_q  <= (state_d == S_DONE) && (err_cnt_d == '0);
        end
    end

    assign wbm_cyc_o        = cyc_q;
    assign wbm_stb_o        = cyc_q;
    assign wbm_we_o         = we_q;
    assign wbm_sel_o        = sel_q;
    assign wbm_adr_o        = adr_q;
    assign wbm_dat_o        = dat_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_cnt;
    assign first_fail_adr_o = ff_adr;

endmodule
